// File: rtl/odo_sbox_prog.sv
// rtl/odo_sbox_prog.sv - runtime-programmable multi-lane S-box lookup unit
//
// Purpose: a single 2^W x W substitution table, written through a streaming
// load port, serving LANES parallel lookups per cycle. Lookup latency is
// 1+OUT_REG cycles (registered table read plus optional output register).
//
// Optional feature macro: ODO_SBOX_PERM_CHECK_EN
//   defined   - a seen-bitmap checks that the loaded table is a permutation
//   undefined - perm_ok simply reports that the table is loaded (state READY)
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   load_start          pulse: begin a full-table load at address 0
//   load_valid/data     next table entry, ascending address order
//   load_done           one-cycle pulse when the last entry is written
//   in_valid/ready/data lookup request, LANES indices of W bits each
//   out_valid/data      lookup result, LANES entries of W bits each
//   perm_ok             table permutation status
module odo_sbox_prog #(
  parameter int W       = 6,
  parameter int LANES   = 4,
  parameter int OUT_REG = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [W-1:0]       load_data,
  output logic               load_done,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  output logic               out_valid,
  output logic [LANES*W-1:0] out_data,
  output logic               perm_ok
);

  localparam int DEPTH = 1 << W;

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t       state;
  logic [W-1:0] addr;
  logic [W-1:0] tbl [DEPTH];

`ifdef ODO_SBOX_PERM_CHECK_EN
  logic [DEPTH-1:0] seen;
  logic             dup;
`endif

  // load_start wins over a same-cycle load_valid, so that entry is dropped.
  logic wr_en;
  logic accept;
  assign wr_en  = (state == LOAD) && load_valid && !load_start && !reset;
  assign accept = in_valid && in_ready;

  // Control FSM; in_ready, load_done and perm_ok are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      addr      <= '0;
      in_ready  <= 1'b0;
      load_done <= 1'b0;
      perm_ok   <= 1'b0;
`ifdef ODO_SBOX_PERM_CHECK_EN
      seen      <= '0;
      dup       <= 1'b0;
`endif
    end else begin
      load_done <= 1'b0;
      if (load_start) begin
        // Valid from every state; a load in progress restarts at address 0.
        state    <= LOAD;
        addr     <= '0;
        in_ready <= 1'b0;
        perm_ok  <= 1'b0;
`ifdef ODO_SBOX_PERM_CHECK_EN
        seen     <= '0;
        dup      <= 1'b0;
`endif
      end else if (state == LOAD && load_valid) begin
        addr <= addr + 1'b1;  // wraps to 0 after the last entry
`ifdef ODO_SBOX_PERM_CHECK_EN
        seen[load_data] <= 1'b1;
        if (seen[load_data]) dup <= 1'b1;
`endif
        if (&addr) begin
          state     <= READY;
          in_ready  <= 1'b1;
          load_done <= 1'b1;
`ifdef ODO_SBOX_PERM_CHECK_EN
          // The last write's own collision is not yet in dup, so fold it in.
          perm_ok   <= !(dup || seen[load_data]);
`else
          perm_ok   <= 1'b1;
`endif
        end
      end
    end
  end

  // Table storage has no reset; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_en) tbl[addr] <= load_data;
  end

  // Registered read stage. Reads only happen in READY and writes only in
  // LOAD, so an in-flight lookup always sees the pre-load contents.
  logic               rd_valid;
  logic [LANES*W-1:0] rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= accept;
      if (accept) begin
        for (int i = 0; i < LANES; i++) begin
          rd_data[i*W +: W] <= tbl[in_data[i*W +: W]];
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic               q_valid;
      logic [LANES*W-1:0] q_data;

      always_ff @(posedge clk) begin
        if (reset) begin
          q_valid <= 1'b0;
          q_data  <= '0;
        end else begin
          q_valid <= rd_valid;
          if (rd_valid) q_data <= rd_data;
        end
      end

      assign out_valid = q_valid;
      assign out_data  = q_data;
    end else begin : g_out_direct
      assign out_valid = rd_valid;
      assign out_data  = rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_odo_sbox_prog.sv
// tb/tb_odo_sbox_prog.sv - self-checking bench for odo_sbox_prog
module tb_odo_sbox_prog;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        load_valid;
  logic [5:0]  load_data;
  logic        in_valid;
  logic [23:0] in_data;

  logic        load_done1, in_ready1, out_valid1, perm_ok1;
  logic [23:0] out_data1;
  logic        load_done0, in_ready0, out_valid0, perm_ok0;
  logic [23:0] out_data0;

  always #5 clk = ~clk;

  odo_sbox_prog #(.W(6), .LANES(4), .OUT_REG(1)) dut1 (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_done(load_done1), .in_valid(in_valid),
    .in_ready(in_ready1), .in_data(in_data), .out_valid(out_valid1),
    .out_data(out_data1), .perm_ok(perm_ok1)
  );

  odo_sbox_prog #(.W(6), .LANES(4), .OUT_REG(0)) dut0 (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_done(load_done0), .in_valid(in_valid),
    .in_ready(in_ready0), .in_data(in_data), .out_valid(out_valid0),
    .out_data(out_data0), .perm_ok(perm_ok0)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [5:0] model [64];
  logic [5:0] ld    [64];

  typedef struct {
    logic [23:0] data;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] pack4(input logic [5:0] a, input logic [5:0] b,
                                        input logic [5:0] c, input logic [5:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [23:0] lookup(input logic [23:0] d);
    logic [23:0] r;
    for (int i = 0; i < 4; i++) r[i*6 +: 6] = model[d[i*6 +: 6]];
    return r;
  endfunction

  function automatic logic exp_perm();
`ifdef ODO_SBOX_PERM_CHECK_EN
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < 64; k++) begin
      if (s[ld[k]]) return 1'b0;
      s[ld[k]] = 1'b1;
    end
    return 1'b1;
`else
    return 1'b1;
`endif
  endfunction

  // Scoreboard: outputs checked first, then the request about to be accepted.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL out1_unexpected cyc=%0d data=%h required no output", cyc, out_data1);
      end else begin
        e = q1.pop_front();
        if (out_data1 !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL out1_data cyc=%0d data=%h required data=%h at cyc=%0d", cyc, out_data1, e.data, e.due);
        end
      end
    end
    if (out_valid0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL out0_unexpected cyc=%0d data=%h required no output", cyc, out_data0);
      end else begin
        e = q0.pop_front();
        if (out_data0 !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL out0_data cyc=%0d data=%h required data=%h at cyc=%0d", cyc, out_data0, e.data, e.due);
        end
      end
    end
    if (reset) begin
      q1.delete();
      q0.delete();
    end else begin
      if (in_valid && in_ready1) begin
        e.data = lookup(in_data);
        e.due  = cyc + 2;
        q1.push_back(e);
      end
      if (in_valid && in_ready0) begin
        e.data = lookup(in_data);
        e.due  = cyc + 1;
        q0.push_back(e);
      end
    end
  end

  // All tasks start and end at posedge+#1.
  task automatic write_range(input int from, input int to, output int early);
    early = 0;
    for (int k = from; k <= to; k++) begin
      load_valid = 1'b1;
      load_data  = ld[k];
      model[k]   = ld[k];
      @(posedge clk); #1;
      if (k != 63 && (load_done1 || load_done0 || in_ready1 || in_ready0)) early++;
    end
    load_valid = 1'b0;
  endtask

  task automatic finish_load(input int early, input string tag);
    logic p;
    p = exp_perm();
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL %s_early early_done_or_ready=%0d required 0", tag, early);
    end
    checks++;
    if (load_done1 !== 1'b1 || load_done0 !== 1'b1 || in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL %s_done load_done=%b%b in_ready=%b%b required 11 11", tag, load_done1, load_done0, in_ready1, in_ready0);
    end
    checks++;
    if (perm_ok1 !== p || perm_ok0 !== p) begin
      errors++;
      $display("FAIL %s_perm perm_ok=%b%b required %b", tag, perm_ok1, perm_ok0, p);
    end
    @(posedge clk); #1;
    checks++;
    if (load_done1 !== 1'b0 || load_done0 !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_width load_done=%b%b required 00", tag, load_done1, load_done0);
    end
  endtask

  task automatic start_load(input string tag);
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    checks++;
    if (in_ready1 !== 1'b0 || perm_ok1 !== 1'b0 || perm_ok0 !== 1'b0) begin
      errors++;
      $display("FAIL %s_loading in_ready=%b perm_ok=%b%b required 0 00", tag, in_ready1, perm_ok1, perm_ok0);
    end
  endtask

  task automatic load_table(input string tag);
    int early;
    start_load(tag);
    write_range(0, 63, early);
    finish_load(early, tag);
  endtask

  task automatic send(input logic [23:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (q1.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d/%0d required 0/0", tag, q1.size(), q0.size());
    end
  endtask

  task automatic set_perm(input int i, input logic [5:0] v);
    logic [5:0] t;
    for (int j = 0; j < 64; j++) begin
      if (ld[j] == v) begin
        t = ld[i]; ld[i] = ld[j]; ld[j] = t;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready1 !== 0 || out_valid1 !== 0 || out_data1 !== 24'h0 || load_done1 !== 0 || perm_ok1 !== 0 ||
        in_ready0 !== 0 || out_valid0 !== 0 || out_data0 !== 24'h0 || load_done0 !== 0 || perm_ok0 !== 0) begin
      errors++;
      $display("FAIL reset_values rdy=%b%b ov=%b%b od=%h/%h done=%b%b perm=%b%b required all zero",
               in_ready1, in_ready0, out_valid1, out_valid0, out_data1, out_data0,
               load_done1, load_done0, perm_ok1, perm_ok0);
    end
    reset = 1'b0;
  endtask

  task automatic test_identity();
    for (int k = 0; k < 64; k++) ld[k] = 6'(k);
    load_table("identity");
    send(pack4(6'h00, 6'h15, 6'h2A, 6'h3F));
    drain("identity");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 64; k++) ld[k] = 6'(k);
    set_perm(0, 6'h14);
    set_perm(1, 6'h09);
    set_perm(2, 6'h37);
    set_perm(3, 6'h1C);
    load_table("perm");
    send(pack4(6'd0, 6'd1, 6'd2, 6'd3));
    send(pack4(6'd3, 6'd2, 6'd1, 6'd0));
    drain("back_to_back");
  endtask

  task automatic test_duplicate();
    for (int k = 0; k < 64; k++) ld[k] = 6'(k);
    ld[5] = 6'h22;
    ld[9] = 6'h22;
    load_table("dup");
    send(pack4(6'd5, 6'd9, 6'd34, 6'd63));
    drain("dup");
  endtask

  task automatic test_restart();
    int early;
    for (int k = 0; k < 64; k++) ld[k] = 6'(63 - k);
    start_load("restart_pre");
    write_range(0, 29, early);
    // load_start with load_valid at addr 30: data must be dropped
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 6'h3F;
    @(posedge clk); #1;
    load_start = 1'b0;
    load_valid = 1'b0;
    for (int k = 0; k < 64; k++) ld[k] = 6'(k) ^ 6'h2A;
    write_range(0, 63, early);
    finish_load(early, "restart");
    send(pack4(6'd0, 6'd30, 6'd31, 6'd63));
    drain("restart");
  endtask

  task automatic test_load_in_ready();
    int early;
    in_valid   = 1'b1;
    in_data    = pack4(6'd0, 6'd1, 6'd2, 6'd3);
    load_start = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    load_start = 1'b0;
    checks++;
    if (in_ready1 !== 1'b0 || in_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL load_in_ready_drop in_ready=%b%b required 00", in_ready1, in_ready0);
    end
    for (int k = 0; k < 64; k++) ld[k] = 6'(k) ^ 6'h15;
    write_range(0, 63, early);
    finish_load(early, "reload");
    send(pack4(6'd0, 6'd1, 6'd2, 6'd3));
    drain("load_in_ready");
  endtask

  task automatic test_reset_mid_lookup();
    send(pack4(6'd7, 6'd8, 6'd9, 6'd10));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drain("reset_lookup");
  endtask

  task automatic test_reset_mid_load();
    int early;
    int bad;
    for (int k = 0; k < 64; k++) ld[k] = 6'(k);
    start_load("reset_load");
    write_range(0, 39, early);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (in_ready1 !== 0 || in_ready0 !== 0 || out_valid1 !== 0 || out_valid0 !== 0 ||
        load_done1 !== 0 || perm_ok1 !== 0) begin
      errors++;
      $display("FAIL reset_mid_load rdy=%b%b ov=%b%b done=%b perm=%b required zero",
               in_ready1, in_ready0, out_valid1, out_valid0, load_done1, perm_ok1);
    end
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid   = 1'b1;
      in_data    = pack4(6'(k), 6'd1, 6'd2, 6'd3);
      load_valid = 1'b1;
      load_data  = 6'(k);
      @(posedge clk); #1;
      if (in_ready1 !== 1'b0 || in_ready0 !== 1'b0 || load_done1 !== 1'b0) bad++;
    end
    in_valid   = 1'b0;
    load_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL empty_blocks bad_cycles=%0d required 0", bad);
    end
    drain("reset_load_idle");
    for (int k = 0; k < 64; k++) ld[k] = 6'(k) ^ 6'h3C;
    load_table("after_reset");
    send(pack4(6'd0, 6'd40, 6'd41, 6'd63));
    drain("after_reset");
  endtask

  initial begin
    reset      = 1'b1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    @(posedge clk); #1;
    test_reset();
    test_identity();
    test_back_to_back();
    test_duplicate();
    test_restart();
    test_load_in_ready();
    test_reset_mid_lookup();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
